// File: rtl/sine_frame_gen_if.sv
// Sample stream from sine_frame_gen toward the FFT input: valid/ready plus a frame-end marker.
interface sine_frame_gen_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/sine_frame_gen.sv
// Frame sample generator: phase accumulator drives the sine ROM address, and a 2-entry
// buffer absorbs the ROM's one-cycle read latency under downstream backpressure.
module sine_frame_gen #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned PHASE_WIDTH = 16,
    parameter int unsigned FRAME_LEN   = 128,
    parameter bit          SIGNED_OUT  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PHASE_WIDTH-1:0] fcw,
    input  logic [PHASE_WIDTH-1:0] phase_init,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    sine_frame_gen_if.master       strm
);
    localparam int unsigned CNT_WIDTH = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN_MASK = DATA_WIDTH'(SIGNED_OUT) << (DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [PHASE_WIDTH-1:0] fcw_q, fcw_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   inflight_q, inflight_last_q, inflight_last_d;
    logic [1:0]             occ_q, occ_d, wr_slot;
    logic [DATA_WIDTH-1:0]  tail_data_q, tail_data_d, head_data_d, cap_data;
    logic                   tail_last_q, tail_last_d, head_last_d;
    logic                   valid_d, busy_d, done_d;
    logic                   issue, pop, credit;

    // Next-state, issue/credit and buffer update
    always_comb begin
        state_d         = state_q;
        phase_d         = phase_q;
        fcw_d           = fcw_q;
        cnt_d           = cnt_q;
        addr_d          = rom_addr;
        issue           = 1'b0;
        inflight_last_d = 1'b0;
        pop             = strm.m_valid & strm.m_ready;
        credit          = (3'(occ_q) + 3'(inflight_q)) < (3'd2 + 3'(pop));
        cap_data        = rom_data ^ SIGN_MASK;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    fcw_d   = fcw;
                    phase_d = phase_init;
                    cnt_d   = '0;
                    addr_d  = phase_init[PHASE_WIDTH-1 -: ADDR_WIDTH];
                end
            end
            RUN: begin
                if (credit) begin
                    issue           = 1'b1;
                    phase_d         = phase_q + fcw_q;
                    addr_d          = phase_d[PHASE_WIDTH-1 -: ADDR_WIDTH];
                    cnt_d           = cnt_q + CNT_WIDTH'(1);
                    inflight_last_d = (cnt_q == LAST_CNT);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Head slot is the registered output; pop shifts the tail forward, push fills the next free slot
        occ_d       = occ_q + 2'(inflight_q) - 2'(pop);
        wr_slot     = occ_q - 2'(pop);
        head_data_d = strm.m_data;
        head_last_d = strm.m_last;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        if (pop && (occ_q == 2'd2)) begin
            head_data_d = tail_data_q;
            head_last_d = tail_last_q;
        end
        if (inflight_q) begin
            if (wr_slot == 2'd0) begin
                head_data_d = cap_data;
                head_last_d = inflight_last_q;
            end else begin
                tail_data_d = cap_data;
                tail_last_d = inflight_last_q;
            end
        end
        valid_d = (occ_d != 2'd0);

        // Leaving DRAIN on the edge that empties the buffer makes done/busy line up with the cycle after the last pop
        if ((state_q == DRAIN) && (occ_d == 2'd0)) begin
            state_d = IDLE;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_q == DRAIN) && (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            phase_q         <= '0;
            fcw_q           <= '0;
            cnt_q           <= '0;
            rom_addr        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= '0;
            tail_data_q     <= '0;
            tail_last_q     <= 1'b0;
            strm.m_data     <= '0;
            strm.m_valid    <= 1'b0;
            strm.m_last     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            state_q         <= state_d;
            phase_q         <= phase_d;
            fcw_q           <= fcw_d;
            cnt_q           <= cnt_d;
            rom_addr        <= addr_d;
            inflight_q      <= issue;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            tail_data_q     <= tail_data_d;
            tail_last_q     <= tail_last_d;
            strm.m_data     <= head_data_d;
            strm.m_valid    <= valid_d;
            strm.m_last     <= head_last_d;
            busy            <= busy_d;
            done            <= done_d;
        end
    end
endmodule

// File: tb/tb_sine_frame_gen.sv
// Self-checking bench for sine_frame_gen: closed-form frame model plus a per-cycle compare process.
module tb_sine_frame_gen;
    localparam int unsigned FL = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start, start1;
    logic [15:0] fcw, phase_init, fcw1, phase_init1;
    logic        busy, done, busy1, done1;
    logic [6:0]  rom_addr, rom_addr1;
    logic [7:0]  rom_data, rom_data1;
    logic [7:0]  rom [128];
    bit          bp = 1'b0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    sine_frame_gen_if #(.DATA_WIDTH(8)) strm  ();
    sine_frame_gen_if #(.DATA_WIDTH(8)) strm1 ();

    sine_frame_gen #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .PHASE_WIDTH(16), .FRAME_LEN(FL), .SIGNED_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .fcw(fcw), .phase_init(phase_init),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data), .strm(strm)
    );

    sine_frame_gen #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .PHASE_WIDTH(16), .FRAME_LEN(1), .SIGNED_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .fcw(fcw1), .phase_init(phase_init1),
        .busy(busy1), .done(done1), .rom_addr(rom_addr1), .rom_data(rom_data1), .strm(strm1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rom_data  <= rom[rom_addr];
        rom_data1 <= rom[rom_addr1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the whole frame is derived in closed form at the accepted start
    logic [8:0]  exp_q[$];
    bit          mb = 1'b0, hs_last_prev = 1'b0, rst_prev = 1'b0, stall_prev = 1'b0;
    logic [7:0]  prev_data, first_data;
    logic        prev_last;
    int          first_valid_cyc = -1, last_hs_cyc = -1;

    always @(negedge clk) begin
        logic [8:0]  e;
        logic [15:0] ph;
        if (rst) begin
            exp_q.delete();
            mb           = 1'b0;
            hs_last_prev = 1'b0;
            stall_prev   = 1'b0;
            rst_prev     = 1'b1;
        end else begin
            if (rst_prev) begin
                chk("rst_valid", 32'(strm.m_valid), 32'd0);
                chk("rst_data",  32'(strm.m_data),  32'd0);
                chk("rst_last",  32'(strm.m_last),  32'd0);
                chk("rst_addr",  32'(rom_addr),     32'd0);
            end
            rst_prev = 1'b0;
            if (hs_last_prev) mb = 1'b0;
            chk("done", 32'(done), 32'(hs_last_prev));
            chk("busy", 32'(busy), 32'(mb));
            if (strm.m_valid && first_valid_cyc < 0) begin
                first_valid_cyc = cyc;
                first_data      = strm.m_data;
            end
            if (stall_prev) begin
                chk("hold_valid", 32'(strm.m_valid), 32'd1);
                chk("hold_data",  32'(strm.m_data),  32'(prev_data));
                chk("hold_last",  32'(strm.m_last),  32'(prev_last));
            end
            hs_last_prev = 1'b0;
            if (strm.m_valid && strm.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_sample", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(strm.m_data), 32'(e[7:0]));
                    chk("last", 32'(strm.m_last), 32'(e[8]));
                    if (e[8]) begin
                        last_hs_cyc  = cyc;
                        hs_last_prev = 1'b1;
                    end
                end
            end
            stall_prev = strm.m_valid && !strm.m_ready;
            prev_data  = strm.m_data;
            prev_last  = strm.m_last;
            if (start && !mb) begin
                mb = 1'b1;
                for (int k = 0; k < int'(FL); k++) begin
                    ph = phase_init + 16'(k) * fcw;
                    exp_q.push_back({(k == int'(FL) - 1), rom[ph[15:9]] ^ 8'h80});
                end
            end
        end
    end

    initial begin
        strm.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            strm.m_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
        end
    end

    int c0;

    // Called at posedge+1; returns at posedge+1 of the cycle after start
    task automatic launch(input logic [15:0] f, input logic [15:0] p);
        fcw             = f;
        phase_init      = p;
        start           = 1'b1;
        c0              = cyc;
        first_valid_cyc = -1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns at posedge+1 of the done cycle
    task automatic wait_done(input int budget, output int dcyc);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < budget);
        chk("done_seen", 32'(done), 32'd1);
        dcyc = cyc;
    endtask

    initial begin
        int dc;
        start = 1'b0; fcw = '0; phase_init = '0;
        start1 = 1'b0; fcw1 = '0; phase_init1 = '0;
        strm1.m_ready = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame with literal timing/data pins
        launch(16'h0200, 16'h0000);
        chk("basic_addr_c1", 32'(rom_addr), 32'd0);
        @(posedge clk); #1;
        chk("basic_addr_c2", 32'(rom_addr), 32'd1);
        wait_done(1000, dc);
        chk("basic_first_valid_cyc", 32'(first_valid_cyc), 32'(c0 + 3));
        chk("basic_first_data", 32'(first_data), 32'h85);
        chk("basic_last_cyc", 32'(last_hs_cyc), 32'(c0 + 130));
        chk("basic_done_cyc", 32'(dc), 32'(c0 + 131));

        // Wrap-around, launched back-to-back in the done cycle
        launch(16'h0400, 16'hFE00);
        chk("wrap_addr_c1", 32'(rom_addr), 32'd127);
        @(posedge clk); #1;
        chk("wrap_addr_c2", 32'(rom_addr), 32'd1);
        wait_done(1000, dc);
        chk("wrap_first_data", 32'(first_data), 32'hE0);
        chk("wrap_done_cyc", 32'(dc), 32'(c0 + 131));
        @(posedge clk); #1;

        // Backpressure plus a start that must be ignored mid-frame
        bp = 1'b1;
        launch(16'h0200, 16'h0000);
        repeat (49) @(posedge clk);
        #1;
        fcw = 16'h1234; phase_init = 16'h5555; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4000, dc);
        chk("bp_done_after_last", 32'(dc), 32'(last_hs_cyc + 1));
        bp = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_no_second_frame", 32'(busy), 32'd0);

        // Reset mid-frame, then a clean frame
        launch(16'h0200, 16'h0000);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy",  32'(busy),         32'd0);
        chk("midrst_valid", 32'(strm.m_valid), 32'd0);
        chk("midrst_addr",  32'(rom_addr),     32'd0);
        @(posedge clk); #1;
        launch(16'h0200, 16'h1200);
        wait_done(1000, dc);
        chk("midrst_first_data", 32'(first_data), 32'hD2);

        // Randomized frames, chained back-to-back
        for (int it = 0; it < 5; it++) begin
            bp = ($urandom_range(0, 1) == 1);
            launch((it == 0) ? 16'h0000 : 16'($urandom), 16'($urandom));
            wait_done(4000, dc);
        end
        bp = 1'b0;
        @(posedge clk); #1;

        // FRAME_LEN=1, zero step
        fcw1 = 16'h0000; phase_init1 = 16'h1200; start1 = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("fl1_busy_c1", 32'(busy1), 32'd1);
        @(posedge clk); #1;
        chk("fl1_valid_c2", 32'(strm1.m_valid), 32'd0);
        @(posedge clk); #1;
        chk("fl1_valid_c3", 32'(strm1.m_valid), 32'd1);
        chk("fl1_data",     32'(strm1.m_data),  32'hD2);
        chk("fl1_last",     32'(strm1.m_last),  32'd1);
        @(posedge clk); #1;
        chk("fl1_done_c4",  32'(done1),         32'd1);
        chk("fl1_busy_c4",  32'(busy1),         32'd0);
        chk("fl1_valid_c4", 32'(strm1.m_valid), 32'd0);
        @(posedge clk); #1;
        chk("fl1_done_c5",  32'(done1),         32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
